// File: rtl/his_builder_fsm.sv
// his_builder_fsm
//   Streams timestamp samples into per-pixel histograms and, at the end of
//   every frame, publishes each pixel's peak bin as a timestamp.
//   The sample order within a frame is acquisition, then pixel, then data,
//   with the data index changing fastest.
//
//   Ports
//     clk        : single clock, rising edge
//     res        : synchronous reset, active low (overrides wrEn)
//     wrEn       : sample-valid qualifier
//     data       : raw timestamp sample; upper BIN_BITS bits select the bin
//     peakResult : per-pixel lower bin edge of the peak bin, last frame
//     peakValid  : one-cycle strobe following a peakResult update
module his_builder_fsm #(
  parameter int Np                = 10,
  parameter int PIXEL_NUM_PER_RAM = 3,
  parameter int ACQ_NUM           = 2,
  parameter int DATA_NUM          = 2,
  parameter int BIN_BITS          = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wrEn,
  input  logic [Np-1:0] data,
  output logic [Np-1:0] peakResult [PIXEL_NUM_PER_RAM-1:0],
  output logic          peakValid
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam int CW    = $clog2(ACQ_NUM*DATA_NUM + 1);
  localparam int AW    = (ACQ_NUM > 1)           ? $clog2(ACQ_NUM)           : 1;
  localparam int PW    = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
  localparam int DW    = (DATA_NUM > 1)          ? $clog2(DATA_NUM)          : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic [AW-1:0]        aIdx;
  logic [PW-1:0]        pIdx;
  logic [DW-1:0]        dIdx;
  logic [CW-1:0]        hist   [PIXEL_NUM_PER_RAM-1:0][NBINS-1:0];
  logic [CW-1:0]        maxCnt [PIXEL_NUM_PER_RAM-1:0];
  logic [BIN_BITS-1:0]  maxBin [PIXEL_NUM_PER_RAM-1:0];

  logic [BIN_BITS-1:0]  bin;
  logic [AW-1:0]        curA;
  logic [PW-1:0]        curP;
  logic [DW-1:0]        curD;
  logic [CW-1:0]        curCnt;
  logic [CW-1:0]        incCnt;
  logic                 newMax;
  logic                 lastD, lastP, lastA, frameEnd;
  logic [CW-1:0]        finCnt [PIXEL_NUM_PER_RAM-1:0];
  logic [BIN_BITS-1:0]  finBin [PIXEL_NUM_PER_RAM-1:0];

  // Only the bin-select bits of a sample carry information here.
  generate
    if (Np > BIN_BITS) begin : gLsb
      logic unusedLsbs;
      assign unusedLsbs = ^data[Np-BIN_BITS-1:0];
    end
  endgenerate

  always_comb begin
    bin    = data[Np-1 -: BIN_BITS];
    // IDLE means no sample of the current frame has been taken yet, so the
    // position is (0,0,0) regardless of the counters.
    curA   = (state == IDLE) ? '0 : aIdx;
    curP   = (state == IDLE) ? '0 : pIdx;
    curD   = (state == IDLE) ? '0 : dIdx;
    curCnt = hist[curP][bin];
    incCnt = (curCnt == CNT_MAX) ? curCnt : curCnt + CW'(1);
    // Strictly greater: on a tie the bin that got there first keeps the peak.
    newMax   = incCnt > maxCnt[curP];
    lastD    = (curD == DW'(DATA_NUM-1));
    lastP    = (curP == PW'(PIXEL_NUM_PER_RAM-1));
    lastA    = (curA == AW'(ACQ_NUM-1));
    frameEnd = lastD && lastP && lastA;
    // Peak tracker including the sample being accepted this edge.
    for (int q = 0; q < PIXEL_NUM_PER_RAM; q++) begin
      finCnt[q] = maxCnt[q];
      finBin[q] = maxBin[q];
      if (PW'(q) == curP && newMax) begin
        finCnt[q] = incCnt;
        finBin[q] = bin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      aIdx      <= '0;
      pIdx      <= '0;
      dIdx      <= '0;
      peakValid <= 1'b0;
      for (int q = 0; q < PIXEL_NUM_PER_RAM; q++) begin
        maxCnt[q]     <= '0;
        maxBin[q]     <= '0;
        peakResult[q] <= '0;
        for (int b = 0; b < NBINS; b++) hist[q][b] <= '0;
      end
    end else begin
      peakValid <= 1'b0;
      if (wrEn) begin
        state <= ACCUM;
        if (frameEnd) begin
          // Publish and start the next frame with empty histograms.
          peakValid <= 1'b1;
          aIdx      <= '0;
          pIdx      <= '0;
          dIdx      <= '0;
          for (int q = 0; q < PIXEL_NUM_PER_RAM; q++) begin
            peakResult[q] <= (finCnt[q] == '0) ? '0
                             : (Np'(finBin[q]) << (Np - BIN_BITS));
            maxCnt[q] <= '0;
            maxBin[q] <= '0;
            for (int b = 0; b < NBINS; b++) hist[q][b] <= '0;
          end
        end else begin
          hist[curP][bin] <= incCnt;
          if (newMax) begin
            maxCnt[curP] <= incCnt;
            maxBin[curP] <= bin;
          end
          if (!lastD) begin
            dIdx <= curD + DW'(1);
            pIdx <= curP;
            aIdx <= curA;
          end else begin
            dIdx <= '0;
            if (!lastP) begin
              pIdx <= curP + PW'(1);
              aIdx <= curA;
            end else begin
              pIdx <= '0;
              aIdx <= curA + AW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
module tb_his_builder_fsm;
  localparam int NP = 10, PN = 3, AN = 2, DN = 2, BB = 4;
  localparam int FRAME = AN*PN*DN;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          wrEn = 1'b0;
  logic [NP-1:0] data = '0;
  logic [NP-1:0] peakResult [PN-1:0];
  logic          peakValid;

  his_builder_fsm #(.Np(NP), .PIXEL_NUM_PER_RAM(PN), .ACQ_NUM(AN),
                    .DATA_NUM(DN), .BIN_BITS(BB)) dut (
    .clk(clk), .res(res), .wrEn(wrEn), .data(data),
    .peakResult(peakResult), .peakValid(peakValid));

  always #5 clk = ~clk;

  int nChk = 0, nPass = 0;

  // Reference model: the list of accepted samples of the current frame.
  int fb[$];
  int expPeak [PN];
  int expValid;

  task automatic check(input string nm, input int act, input int exp);
    nChk++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Peak of pixel p: replay the frame's samples in arrival order; a bin
  // becomes the peak only when its count strictly beats the best so far.
  function automatic int peakOf(input int p);
    int cnt [1<<BB];
    int mc = 0, mb = 0;
    for (int b = 0; b < (1<<BB); b++) cnt[b] = 0;
    for (int k = 0; k < fb.size(); k++) begin
      if ((k / DN) % PN == p) begin
        cnt[fb[k]]++;
        if (cnt[fb[k]] > mc) begin mc = cnt[fb[k]]; mb = fb[k]; end
      end
    end
    return (mc == 0) ? 0 : mb * (1 << (NP-BB));
  endfunction

  task automatic modelEdge(input logic r, input logic w, input int d);
    expValid = 0;
    if (!r) begin
      fb.delete();
      for (int p = 0; p < PN; p++) expPeak[p] = 0;
    end else if (w) begin
      fb.push_back(d >> (NP-BB));
      if (fb.size() == FRAME) begin
        for (int p = 0; p < PN; p++) expPeak[p] = peakOf(p);
        expValid = 1;
        fb.delete();
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input int d);
    res = r; wrEn = w; data = NP'(d);
    @(posedge clk);
    modelEdge(r, w, d);
    #1;
    check("valid", int'(peakValid), expValid);
    for (int p = 0; p < PN; p++) check($sformatf("peak%0d", p), int'(peakResult[p]), expPeak[p]);
  endtask

  typedef struct {
    logic r, w;
    int   d;
    int   ev, e0, e1, e2;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic w, input int d,
                              input int ev, input int e0, input int e1, input int e2);
    vec_t v;
    v.r = r; v.w = w; v.d = d; v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  int f1 [FRAME] = '{108, 100, 1022, 1022, 700, 700, 120, 511, 90, 90, 5, 5};
  int f2 [FRAME] = '{0, 0, 1023, 1023, 0, 1023, 0, 0, 1023, 1023, 1023, 0};

  initial begin
    for (int p = 0; p < PN; p++) expPeak[p] = 0;
    expValid = 0;

    // Directed table: reset, idle, two known frames, data boundaries.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < FRAME-1; k++) tbl.push_back(mk(1, 1, f1[k], 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, f1[FRAME-1], 1, 64, 960, 640));
    tbl.push_back(mk(1, 0, 0, 0, 64, 960, 640));
    for (int k = 0; k < FRAME-1; k++) tbl.push_back(mk(1, 1, f2[k], 0, 64, 960, 640));
    tbl.push_back(mk(1, 1, f2[FRAME-1], 1, 0, 960, 960));
    tbl.push_back(mk(1, 0, 0, 0, 0, 960, 960));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d);
      check($sformatf("tbl%0d_valid", i), int'(peakValid), tbl[i].ev);
      check($sformatf("tbl%0d_pk0", i), int'(peakResult[0]), tbl[i].e0);
      check($sformatf("tbl%0d_pk1", i), int'(peakResult[1]), tbl[i].e1);
      check($sformatf("tbl%0d_pk2", i), int'(peakResult[2]), tbl[i].e2);
    end

    // Back-to-back frames; pixel 2 of the second frame is all 600.
    for (int k = 0; k < FRAME; k++) step(1, 1, $urandom_range(0, 1023));
    check("b2b_frame1_valid", int'(peakValid), 1);
    for (int k = 0; k < FRAME; k++) begin
      step(1, 1, ((k / DN) % PN == 2) ? 600 : $urandom_range(0, 1023));
      if (k < FRAME-1) check("b2b_early_valid", int'(peakValid), 0);
    end
    check("b2b_frame2_valid", int'(peakValid), 1);
    check("b2b_pk2", int'(peakResult[2]), 576);

    // wrEn gap mid-frame: the frame still needs exactly 12 accepted samples.
    for (int k = 0; k < 7; k++) step(1, 1, $urandom_range(0, 1023));
    for (int k = 0; k < 5; k++) step(1, 0, $urandom_range(0, 1023));
    for (int k = 0; k < 4; k++) step(1, 1, $urandom_range(0, 1023));
    check("gap_early_valid", int'(peakValid), 0);
    step(1, 1, 300);
    check("gap_end_valid", int'(peakValid), 1);

    // Mid-frame reset discards the partial frame.
    for (int k = 0; k < 7; k++) step(1, 1, $urandom_range(0, 1023));
    step(0, 1, 1000);
    check("rst_pk0", int'(peakResult[0]), 0);
    check("rst_pk1", int'(peakResult[1]), 0);
    check("rst_valid", int'(peakValid), 0);
    for (int k = 0; k < FRAME; k++) step(1, 1, f1[k]);
    check("rst_fresh_pk0", int'(peakResult[0]), 64);
    check("rst_fresh_pk1", int'(peakResult[1]), 960);
    check("rst_fresh_pk2", int'(peakResult[2]), 640);

    // Random traffic against the model; few bins in play so ties are common.
    for (int i = 0; i < 600; i++) begin
      int d;
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = 1023;
        default: d = $urandom_range(0, 3) * 256 + $urandom_range(0, 255);
      endcase
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), d);
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
